// File: rtl/alu_port_arbiter.sv
// Round-robin owner of the shared 16-bit ALU between the microcode sequencer (port 0)
// and the EA/prefetch unit (port 1); registered result tagged with the issuing port.
module alu_port_arbiter #(
  parameter int unsigned          OP_WIDTH = 6,
  parameter logic [OP_WIDTH-1:0]  IDLE_OP  = '0,
  parameter int unsigned          MAX_LOCK = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0,
  input  logic                req1,
  input  logic                lock0,
  input  logic                lock1,
  input  logic [15:0]         a0,
  input  logic [15:0]         b0,
  input  logic [15:0]         a1,
  input  logic [15:0]         b1,
  input  logic [OP_WIDTH-1:0] op0,
  input  logic [OP_WIDTH-1:0] op1,
  output logic                gnt0,
  output logic                gnt1,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output logic [OP_WIDTH-1:0] alu_op,
  input  logic [15:0]         alu_out,
  output logic [15:0]         result,
  output logic                result_valid,
  output logic                result_port
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  state_t      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic [15:0] result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        result_port_q, result_port_d;

  logic        accept0, accept1;
  logic        cur, req_cur, lock_cur, req_oth;
  logic [7:0]  lock_cnt_inc;

  function automatic state_t arbitrate(input logic r0, input logic r1, input logic last);
    state_t s;
    if (r0 && r1)  s = last ? OWN0 : OWN1;
    else if (r0)   s = OWN0;
    else if (r1)   s = OWN1;
    else           s = IDLE;
    return s;
  endfunction

  assign gnt0    = (state_q == OWN0);
  assign gnt1    = (state_q == OWN1);
  assign accept0 = gnt0 & req0;
  assign accept1 = gnt1 & req1;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = IDLE_OP;
    if (gnt0) begin
      alu_a  = a0;
      alu_b  = b0;
      alu_op = op0;
    end else if (gnt1) begin
      alu_a  = a1;
      alu_b  = b1;
      alu_op = op1;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_owner_d   = last_owner_q;
    lock_cnt_d     = lock_cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    result_port_d  = result_port_q;

    cur          = (state_q == OWN1);
    req_cur      = cur ? req1  : req0;
    lock_cur     = cur ? lock1 : lock0;
    req_oth      = cur ? req0  : req1;
    // Count includes the op being accepted, so the forced release lands on the MAX_LOCK-th op.
    lock_cnt_inc = lock_cnt_q + 8'd1;

    if (accept0 || accept1) begin
      result_d       = alu_out;
      result_valid_d = 1'b1;
      result_port_d  = accept1;
      last_owner_d   = accept1;
    end

    case (state_q)
      IDLE: begin
        state_d    = arbitrate(req0, req1, last_owner_q);
        lock_cnt_d = '0;
      end
      OWN0, OWN1: begin
        if (req_cur && lock_cur) begin
          if (lock_cnt_inc < MAX_CNT) begin
            lock_cnt_d = lock_cnt_inc;
          end else if (req_oth) begin
            state_d    = cur ? OWN0 : OWN1;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = '0;
          end
        end else begin
          state_d    = arbitrate(req0, req1, last_owner_d);
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_owner_q   <= 1'b1;
      lock_cnt_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_port_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      lock_cnt_q     <= lock_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_port_q  <= result_port_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign result_port  = result_port_q;

endmodule

// File: tb/tb_alu_port_arbiter.sv
module tb_alu_port_arbiter;

  localparam int unsigned   OP_W    = 6;
  localparam logic [OP_W-1:0] IDLE_OP = 6'd0;
  localparam logic [OP_W-1:0] SELA    = 6'd0;
  localparam logic [OP_W-1:0] SELB    = 6'd1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            req0, req1, lock0, lock1;
  logic [15:0]     a0, b0, a1, b1;
  logic [OP_W-1:0] op0, op1;
  logic            gnt0, gnt1;
  logic [15:0]     alu_a, alu_b, alu_out, result;
  logic [OP_W-1:0] alu_op;
  logic            result_valid, result_port;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: SELA, SELB, anything else adds.
  always_comb begin
    case (alu_op)
      SELA:    alu_out = alu_a;
      SELB:    alu_out = alu_b;
      default: alu_out = alu_a + alu_b;
    endcase
  end

  alu_port_arbiter #(
    .OP_WIDTH (OP_W),
    .IDLE_OP  (IDLE_OP),
    .MAX_LOCK (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0         (req0),
    .req1         (req1),
    .lock0        (lock0),
    .lock1        (lock1),
    .a0           (a0),
    .b0           (b0),
    .a1           (a1),
    .b1           (b1),
    .op0          (op0),
    .op1          (op1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .result       (result),
    .result_valid (result_valid),
    .result_port  (result_port)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
    tick;
    tick;
    vectors++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt: got %b%b expected 00", gnt0, gnt1); end
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    vectors++; if (result !== 16'h0000 || result_port !== 1'b0) begin miscompares++; $display("FAIL reset_result: got %h/%b expected 0000/0", result, result_port); end
    vectors++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== IDLE_OP) begin miscompares++; $display("FAIL reset_alu: got %h %h %h expected 0 0 %h", alu_a, alu_b, alu_op, IDLE_OP); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    a0 = 16'h1234; op0 = SELA; req0 = 1'b1;
    tick;
    vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL basic_gnt: got %b%b expected 10", gnt0, gnt1); end
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid: got %b expected 0", result_valid); end
    vectors++; if (alu_a !== 16'h1234 || alu_op !== SELA) begin miscompares++; $display("FAIL basic_alu_in: got %h %h expected 1234 %h", alu_a, alu_op, SELA); end
    tick;
    vectors++; if (result_valid !== 1'b1 || result !== 16'h1234 || result_port !== 1'b0) begin miscompares++; $display("FAIL basic_result: got %b %h %b expected 1 1234 0", result_valid, result, result_port); end
    req0 = 1'b0;
    tick;
    vectors++; if (result_valid !== 1'b0 || gnt0 !== 1'b0) begin miscompares++; $display("FAIL basic_release: got valid %b gnt0 %b expected 0 0", result_valid, gnt0); end
  endtask

  task automatic test_alternate;
    logic exp_g1;
    a0 = 16'h1111; op0 = SELA;
    a1 = 16'h0000; b1 = 16'hBEEF; op1 = SELB;
    req0 = 1'b1; req1 = 1'b1;
    // last owner is port 0 here, so port 1 takes the first tie
    for (int i = 0; i < 8; i++) begin
      tick;
      exp_g1 = (i % 2 == 0);
      vectors++; if (gnt1 !== exp_g1 || gnt0 !== !exp_g1) begin miscompares++; $display("FAIL alt_gnt[%0d]: got %b%b expected %b%b", i, gnt0, gnt1, !exp_g1, exp_g1); end
      if (i == 0) begin
        vectors++; if (alu_b !== 16'hBEEF || alu_op !== SELB) begin miscompares++; $display("FAIL alt_mux1: got %h %h expected beef %h", alu_b, alu_op, SELB); end
      end else begin
        vectors++; if (result_valid !== 1'b1 || result_port !== !exp_g1) begin miscompares++; $display("FAIL alt_port[%0d]: got %b %b expected 1 %b", i, result_valid, result_port, !exp_g1); end
        vectors++; if (result !== (exp_g1 ? 16'h1111 : 16'hBEEF)) begin miscompares++; $display("FAIL alt_result[%0d]: got %h expected %h", i, result, exp_g1 ? 16'h1111 : 16'hBEEF); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick;
    vectors++; if (result_valid !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL alt_drain: got %b %b%b expected 0 00", result_valid, gnt0, gnt1); end
    tick;
  endtask

  task automatic test_lock;
    logic exp_g1, exp_p1;
    a0 = 16'h5A5A; op0 = SELA; lock0 = 1'b1; req0 = 1'b1;
    b1 = 16'hBEEF; op1 = SELB; lock1 = 1'b0; req1 = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick;
      exp_g1 = (t == 9);
      exp_p1 = (t == 10);
      vectors++; if (gnt1 !== exp_g1 || gnt0 !== !exp_g1) begin miscompares++; $display("FAIL lock_gnt[%0d]: got %b%b expected %b%b", t, gnt0, gnt1, !exp_g1, exp_g1); end
      if (t == 1) begin
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL lock_first_valid: got %b expected 0", result_valid); end
      end else begin
        vectors++; if (result_valid !== 1'b1 || result_port !== exp_p1 || result !== (exp_p1 ? 16'hBEEF : 16'h5A5A)) begin
          miscompares++; $display("FAIL lock_result[%0d]: got %b %b %h expected 1 %b %h", t, result_valid, result_port, result, exp_p1, exp_p1 ? 16'hBEEF : 16'h5A5A);
        end
      end
    end
  endtask

  task automatic test_reset_pulse;
    #3;
    reset_n = 1'b0;
    #1;
    vectors++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL pulse_async: got %b%b %b expected 00 0", gnt0, gnt1, result_valid); end
    vectors++; if (result !== 16'h0 || result_port !== 1'b0) begin miscompares++; $display("FAIL pulse_result: got %h %b expected 0000 0", result, result_port); end
    tick;
    vectors++; if (gnt0 !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL pulse_held: got %b %b expected 0 0", gnt0, result_valid); end
    reset_n = 1'b1;
    lock0 = 1'b0;
    tick;
    vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL pulse_tie: got %b%b %b expected 10 0", gnt0, gnt1, result_valid); end
    tick;
    vectors++; if (result_valid !== 1'b1 || result_port !== 1'b0 || result !== 16'h5A5A || gnt1 !== 1'b1) begin
      miscompares++; $display("FAIL pulse_after: got %b %b %h gnt1 %b expected 1 0 5a5a 1", result_valid, result_port, result, gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_withdraw;
    op1 = 6'h3F; req1 = 1'b1;
    tick;
    vectors++; if (gnt1 !== 1'b1 || alu_op !== 6'h3F) begin miscompares++; $display("FAIL wd_gnt: got %b %h expected 1 3f", gnt1, alu_op); end
    req1 = 1'b0;
    tick;
    vectors++; if (result_valid !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL wd_release: got %b %b%b expected 0 00", result_valid, gnt0, gnt1); end
    vectors++; if (result !== 16'h5A5A) begin miscompares++; $display("FAIL wd_hold: got %h expected 5a5a", result); end
  endtask

  task automatic test_idle;
    a0 = 16'hFFFF; b0 = 16'hAAAA; a1 = 16'h5555; b1 = 16'h1234; op0 = 6'd3; op1 = 6'd5;
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      vectors++; if (alu_op !== IDLE_OP || alu_a !== 16'h0 || alu_b !== 16'h0) begin miscompares++; $display("FAIL idle_alu[%0d]: got %h %h %h expected %h 0 0", i, alu_op, alu_a, alu_b, IDLE_OP); end
      vectors++; if (result_valid !== 1'b0 || result !== 16'h5A5A || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
        miscompares++; $display("FAIL idle_out[%0d]: got %b %h %b%b expected 0 5a5a 00", i, result_valid, result, gnt0, gnt1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_alternate;
    test_lock;
    test_reset_pulse;
    test_withdraw;
    test_idle;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
